// File: rtl/controlador_pedidos.sv
// -----------------------------------------------------------------------------
// controlador_pedidos
// Order controller for a coffee machine. It keeps a count of pending orders,
// dispatches one at a time to the machine with a single-cycle start pulse,
// follows the machine's state code until the extraction is finished, and
// declares a sticky error if the machine stalls for too long.
//
// Parameters
//   PROF           maximum number of pending orders (1..7)
//   TIMEOUT        wait cycles allowed in a waiting state before ERRO (1..255)
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   pedido         one new order per cycle sampled high
//   maq_state      machine state code (1 = idle, 9 = extraction)
//   start          one-cycle dispatch request (high while in DISPARO)
//   fila_cont      number of pending orders
//   fila_cheia     high when fila_cont == PROF
//   pedido_perdido one-cycle pulse after an order was dropped
//   servidos       completed coffees, saturating at 255
//   ocupado        high in DISPARO, AGUARDA_INICIO and AGUARDA_FIM
//   erro_timeout   high while in ERRO
// -----------------------------------------------------------------------------
module controlador_pedidos #(
    parameter int PROF    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pedido,
    input  logic [3:0] maq_state,
    output logic       start,
    output logic [2:0] fila_cont,
    output logic       fila_cheia,
    output logic       pedido_perdido,
    output logic [7:0] servidos,
    output logic       ocupado,
    output logic       erro_timeout
);

    localparam logic [2:0] OCIOSO         = 3'd0;
    localparam logic [2:0] DISPARO        = 3'd1;
    localparam logic [2:0] AGUARDA_INICIO = 3'd2;
    localparam logic [2:0] AGUARDA_FIM    = 3'd3;
    localparam logic [2:0] ERRO           = 3'd4;

    localparam logic [3:0] MAQ_IDLE     = 4'd1;
    localparam logic [3:0] MAQ_EXTRACAO = 4'd9;

    localparam logic [2:0] PROF_C       = 3'(PROF);
    // The timer holds the number of wait cycles already spent, so the cycle
    // seen with TIMEOUT-1 is the last one allowed before ERRO.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] fila_q, fila_d;
    logic [7:0] servidos_q, servidos_d;
    logic       perdido_q, perdido_d;
    logic       deq;

    // Dequeue happens on the edge that leaves DISPARO.
    assign deq = (state_q == DISPARO);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        servidos_d = servidos_q;

        case (state_q)
            OCIOSO: begin
                if (fila_q != 3'd0 && maq_state == MAQ_IDLE) begin
                    state_d = DISPARO;
                end
            end
            DISPARO: begin
                state_d = AGUARDA_INICIO;
            end
            AGUARDA_INICIO: begin
                // Exit condition is tested first so it wins over the timeout.
                if (maq_state != MAQ_IDLE) begin
                    state_d = AGUARDA_FIM;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ERRO;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            AGUARDA_FIM: begin
                if (maq_state == MAQ_EXTRACAO) begin
                    state_d = OCIOSO;
                    if (servidos_q != 8'hFF) begin
                        servidos_d = servidos_q + 8'd1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ERRO;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ERRO: begin
                state_d = ERRO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = 8'd0;
        end
    end

    // Queue counter: a simultaneous enqueue and dequeue cancel out, so an
    // order arriving in DISPARO is never dropped even with a full queue.
    always_comb begin
        fila_d    = fila_q;
        perdido_d = 1'b0;
        if (pedido && !deq) begin
            if (fila_q < PROF_C) begin
                fila_d = fila_q + 3'd1;
            end else begin
                perdido_d = 1'b1;
            end
        end else if (!pedido && deq) begin
            fila_d = fila_q - 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCIOSO;
            timer_q    <= 8'd0;
            fila_q     <= 3'd0;
            servidos_q <= 8'd0;
            perdido_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fila_q     <= fila_d;
            servidos_q <= servidos_d;
            perdido_q  <= perdido_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign start          = (state_q == DISPARO);
    assign fila_cont      = fila_q;
    assign fila_cheia     = (fila_q == PROF_C);
    assign pedido_perdido = perdido_q;
    assign servidos       = servidos_q;
    assign ocupado        = (state_q == DISPARO) || (state_q == AGUARDA_INICIO) ||
                            (state_q == AGUARDA_FIM);
    assign erro_timeout   = (state_q == ERRO);

endmodule

// File: doc/controlador_pedidos.md
CONTROLADOR_PEDIDOS -- requirements
Module: controlador_pedidos

Interface
REQ-001 The block SHALL have parameter PROF, default 4, meaning the maximum number of pending coffee orders (range 1..7).
REQ-002 The block SHALL have parameter TIMEOUT, default 32, meaning the number of wait cycles allowed before an error is declared (range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pedido, input, 1 bit: each cycle sampled high is one new order.
REQ-006 The block SHALL have port maq_state, input, 4 bits: the state code of the coffee machine (IDLE=1, LIGAR_MAQUINA=2, REALIZAR_EXTRACAO=9).
REQ-007 The block SHALL have port start, output, 1 bit: a one-cycle request to the coffee machine.
REQ-008 The block SHALL have port fila_cont, output, 3 bits: the number of pending orders.
REQ-009 The block SHALL have port fila_cheia, output, 1 bit: high when fila_cont == PROF.
REQ-010 The block SHALL have port pedido_perdido, output, 1 bit: a one-cycle pulse when an order is dropped.
REQ-011 The block SHALL have port servidos, output, 8 bits: the count of completed coffees.
REQ-012 The block SHALL have port ocupado, output, 1 bit: high in DISPARO, AGUARDA_INICIO and AGUARDA_FIM.
REQ-013 The block SHALL have port erro_timeout, output, 1 bit: high while in ERRO.

Function
REQ-014 The FSM SHALL have exactly these states: OCIOSO, DISPARO, AGUARDA_INICIO, AGUARDA_FIM, ERRO.
REQ-015 In OCIOSO, the FSM SHALL go to DISPARO when fila_cont > 0 and maq_state == 1; otherwise it SHALL stay in OCIOSO.
REQ-016 start SHALL be 1 for exactly the one cycle the FSM is in DISPARO and 0 in all other cycles; DISPARO SHALL always go to AGUARDA_INICIO.
REQ-017 The order queue SHALL decrement by 1 on the edge leaving DISPARO.
REQ-018 In AGUARDA_INICIO, the FSM SHALL go to AGUARDA_FIM when maq_state != 1.
REQ-019 In AGUARDA_FIM, when maq_state == 9, servidos SHALL increment (saturating at 255) and the FSM SHALL go to OCIOSO.
REQ-020 Timeout: an 8-bit timer SHALL be cleared on every state change; it SHALL count up in AGUARDA_INICIO and AGUARDA_FIM; when it reaches TIMEOUT without the exit condition, the FSM SHALL go to ERRO.
REQ-021 ERRO SHALL be sticky until rst_n is asserted; start SHALL remain 0 and the queue SHALL keep accepting and dropping orders per REQ-022 to REQ-024.
REQ-022 Enqueue: pedido=1 with fila_cont < PROF SHALL increment fila_cont on that edge.
REQ-023 Drop: pedido=1 with fila_cont == PROF and no dequeue in that cycle SHALL leave fila_cont unchanged and pulse pedido_perdido high for the next cycle.
REQ-024 Simultaneous enqueue and dequeue (pedido=1 while in DISPARO) SHALL leave fila_cont unchanged and SHALL NOT drop the order, even when full.
REQ-025 The exit conditions SHALL take priority over the timeout when both are true in the same cycle.
REQ-026 Undefined FSM encodings SHALL go to OCIOSO on the next edge.
REQ-027 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from pedido or maq_state to any output.

Reset
REQ-028 While rst_n=0, asynchronously, the block SHALL hold: FSM=OCIOSO, fila_cont=0, timer=0, servidos=0, start=0, fila_cheia=0, pedido_perdido=0, ocupado=0, erro_timeout=0.
REQ-029 Reset asserted mid-operation (any state, any queue level) SHALL discard all pending orders; no start SHALL be issued in the first cycle after release.

Verification
REQ-030 Single order: a bench model of the machine (IDLE=1 -> 2 on start, ..., 9 -> 1) and pedido=1 for 1 cycle -> fila_cont=1; start high exactly 1 cycle; fila_cont returns to 0; servidos=1 after state 9; ocupado drops when the FSM returns to OCIOSO.
REQ-031 Overflow: with maq_state held at 5, pedido=1 for 6 cycles -> fila_cont saturates at 4, fila_cheia=1, pedido_perdido pulses 2 times.
REQ-032 Full plus dispatch: queue=4, pedido=1 in the DISPARO cycle -> fila_cont stays 4 and there is no pedido_perdido.
REQ-033 Timeout: after start, maq_state held at 1 -> erro_timeout=1 after 32 wait cycles; later pedidos queue up but start stays 0; rst_n pulse -> all outputs return to their reset values.
REQ-034 Back-to-back: 3 queued orders -> 3 start pulses, each only after maq_state has returned to 1; servidos=3.
REQ-035 Saturation: 256 completed cycles (servidos forced or run) -> servidos=255 and does not wrap.
